// File: rtl/bank_window_mapper.sv
// rtl/bank_window_mapper.sv - bank register pair with (zp),Y indirect-cycle tracking and key-unlocked bank width
module bank_window_mapper #(
  parameter int         ADDR_WIDTH = 16,
  parameter int         BANK_WIDTH = 8,
  parameter int         LOCK_WIDTH = 4,
  parameter logic [7:0] RESET_BANK = 8'h0F,
  parameter logic [7:0] OPC_MASK   = 8'hDF,
  parameter logic [7:0] OPC_MATCH  = 8'h91,
  parameter logic [7:0] KEY0       = 8'h55,
  parameter logic [7:0] KEY1       = 8'hAA,
  parameter logic [7:0] KEY2       = 8'h00
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rdy,
  input  logic                  sync,
  input  logic                  r_w,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  output logic                  data_oe,
  output logic [BANK_WIDTH-1:0] bank,
  output logic                  full,
  output logic                  sel_indirect
);

  typedef enum logic [2:0] {S_IDLE, S_ZP, S_PLO, S_PHI, S_D1, S_D2} ind_state_t;
  typedef enum logic [1:0] {K0, K1, K2, K3} key_state_t;

  localparam logic [BANK_WIDTH-1:0] RST_BANK  = RESET_BANK[BANK_WIDTH-1:0];
  localparam int unsigned           MASK_INT  = (1 << LOCK_WIDTH) - 1;
  localparam logic [BANK_WIDTH-1:0] LOCK_MASK = MASK_INT[BANK_WIDTH-1:0];

  logic [BANK_WIDTH-1:0] exec_bank, indir_bank, rd_sel, eff;
  logic                  hit, wr_exec, wr_indir, opc_hit, key_step, full_next;
  ind_state_t            ind_state, ind_next;
  key_state_t            key_state, key_next;

  assign hit      = (address[ADDR_WIDTH-1:1] == '0);
  assign wr_exec  = hit & ~r_w & ~address[0];
  assign wr_indir = hit & ~r_w & address[0];
  assign opc_hit  = sync & ((data_in & OPC_MASK) == OPC_MATCH);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exec_bank  <= RST_BANK;
      indir_bank <= RST_BANK;
    end else begin
      if (wr_exec)  exec_bank  <= data_in[BANK_WIDTH-1:0];
      if (wr_indir) indir_bank <= data_in[BANK_WIDTH-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ind_state <= S_IDLE;
    else       ind_state <= ind_next;
  end

  // A sync seen before the data cycles means the instruction was abandoned (interrupt).
  always_comb begin
    ind_next = ind_state;
    if (rdy) begin
      case (ind_state)
        S_IDLE:  if (opc_hit) ind_next = S_ZP;
        S_ZP:    ind_next = sync ? (opc_hit ? S_ZP : S_IDLE) : S_PLO;
        S_PLO:   ind_next = sync ? (opc_hit ? S_ZP : S_IDLE) : S_PHI;
        S_PHI:   ind_next = sync ? (opc_hit ? S_ZP : S_IDLE) : S_D1;
        S_D1:    ind_next = S_D2;
        S_D2:    ind_next = opc_hit ? S_ZP : S_IDLE;
        default: ind_next = S_IDLE;
      endcase
    end
  end

  // D2 is the page-cross or store cycle; if sync is already up, it is the next opcode fetch.
  assign sel_indirect = (ind_state == S_D1) | ((ind_state == S_D2) & ~sync);

  assign key_step = wr_indir & ~sel_indirect;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_state <= K0;
      full      <= 1'b0;
    end else begin
      key_state <= key_next;
      full      <= full_next;
    end
  end

  always_comb begin
    key_next  = key_state;
    full_next = full;
    if (key_step) begin
      case (key_state)
        K0:      if (data_in == KEY0) key_next = K1;
        K1:      key_next = (data_in == KEY1) ? K2 : K0;
        K2:      key_next = (data_in == KEY2) ? K3 : K0;
        K3: begin
          full_next = data_in[0];
          key_next  = K0;
        end
        default: key_next = K0;
      endcase
    end
  end

  assign eff      = sel_indirect ? indir_bank : exec_bank;
  assign bank     = full ? eff : (eff & LOCK_MASK);
  assign rd_sel   = address[0] ? indir_bank : exec_bank;
  assign data_oe  = hit & r_w;
  assign data_out = 8'(full ? rd_sel : (rd_sel & LOCK_MASK));

endmodule

// File: tb/tb_bank_window_mapper.sv
// tb/tb_bank_window_mapper.sv - scoreboard bench for bank_window_mapper
module tb_bank_window_mapper;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rdy = 1'b1;
  logic        sync = 1'b0;
  logic        r_w = 1'b1;
  logic [15:0] address = 16'h8000;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [7:0]  bank;
  logic        full;
  logic        sel_indirect;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [7:0] bank;
    logic       sel;
    logic       full;
  } exp_t;

  typedef struct packed {
    logic       sync;
    logic [7:0] op;
    logic       rdy;
    logic [7:0] bank;
    logic       sel;
  } row_t;

  exp_t sb[$];

  bank_window_mapper dut (
    .clock(clock), .reset(reset), .rdy(rdy), .sync(sync), .r_w(r_w),
    .address(address), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .bank(bank), .full(full), .sel_indirect(sel_indirect)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  function automatic row_t mk(logic s, logic [7:0] op, logic r, logic [7:0] b, logic sel);
    row_t x;
    x.sync = s; x.op = op; x.rdy = r; x.bank = b; x.sel = sel;
    return x;
  endfunction

  task automatic cyc(input logic s, input logic rw, input logic [15:0] a, input logic [7:0] d, input logic rd);
    @(posedge clock);
    #1;
    sync = s; r_w = rw; address = a; data_in = d; rdy = rd;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cyc(1'b0, 1'b0, a, d, 1'b1);
  endtask

  task automatic test_reset;
    exp_t e;
    #1 reset = 1'b1;
    #2;
    sb.push_back('{bank: 8'h0F, sel: 1'b0, full: 1'b0});
    e = sb.pop_front();
    total++; if (bank !== e.bank) $display("FAIL reset_bank got %h want %h", bank, e.bank); else passed++;
    total++; if (full !== e.full) $display("FAIL reset_full got %b want %b", full, e.full); else passed++;
    total++; if (sel_indirect !== e.sel) $display("FAIL reset_sel got %b want %b", sel_indirect, e.sel); else passed++;
    @(negedge clock) reset = 1'b0;
    for (int a = 0; a < 2; a++) begin
      cyc(1'b0, 1'b1, 16'(a), 8'h00, 1'b1);
      @(negedge clock);
      total++; if (data_oe !== 1'b1) $display("FAIL reset_read_oe addr %0d got %b want 1", a, data_oe); else passed++;
      total++; if (data_out !== 8'h0F) $display("FAIL reset_read addr %0d got %h want 0f", a, data_out); else passed++;
    end
    cyc(1'b0, 1'b1, 16'h2000, 8'h00, 1'b1);
    @(negedge clock);
    total++; if (data_oe !== 1'b0) $display("FAIL no_hit_oe got %b want 0", data_oe); else passed++;
  endtask

  task automatic test_unlock;
    exp_t e;
    wr(16'h0000, 8'h3A);
    cyc(1'b0, 1'b1, 16'h0000, 8'h00, 1'b1);
    sb.push_back('{bank: 8'h0A, sel: 1'b0, full: 1'b0});
    @(negedge clock);
    e = sb.pop_front();
    total++; if (bank !== e.bank) $display("FAIL locked_bank got %h want %h", bank, e.bank); else passed++;
    total++; if (data_out !== 8'h0A) $display("FAIL locked_read got %h want 0a", data_out); else passed++;
    wr(16'h0001, 8'h55); wr(16'h0001, 8'hAA); wr(16'h0001, 8'h00); wr(16'h0001, 8'h01);
    cyc(1'b0, 1'b1, 16'h0000, 8'h00, 1'b1);
    sb.push_back('{bank: 8'h3A, sel: 1'b0, full: 1'b1});
    @(negedge clock);
    e = sb.pop_front();
    total++; if (full !== e.full) $display("FAIL unlock_full got %b want %b", full, e.full); else passed++;
    total++; if (bank !== e.bank) $display("FAIL unlock_bank got %h want %h", bank, e.bank); else passed++;
    total++; if (data_out !== 8'h3A) $display("FAIL unlock_read got %h want 3a", data_out); else passed++;
  endtask

  task automatic test_relock_wrong_key;
    exp_t e;
    wr(16'h0001, 8'h55); wr(16'h0001, 8'hAA); wr(16'h0001, 8'h00); wr(16'h0001, 8'h00);
    cyc(1'b0, 1'b1, 16'h0000, 8'h00, 1'b1);
    sb.push_back('{bank: 8'h0A, sel: 1'b0, full: 1'b0});
    @(negedge clock);
    e = sb.pop_front();
    total++; if (full !== e.full) $display("FAIL relock_full got %b want %b", full, e.full); else passed++;
    total++; if (bank !== e.bank) $display("FAIL relock_bank got %h want %h", bank, e.bank); else passed++;
    wr(16'h0001, 8'h55); wr(16'h0001, 8'hAB); wr(16'h0001, 8'h00); wr(16'h0001, 8'h01);
    cyc(1'b0, 1'b1, 16'h0001, 8'h00, 1'b1);
    sb.push_back('{bank: 8'h0A, sel: 1'b0, full: 1'b0});
    @(negedge clock);
    e = sb.pop_front();
    total++; if (full !== e.full) $display("FAIL wrong_key_full got %b want %b", full, e.full); else passed++;
    total++; if (data_out !== 8'h01) $display("FAIL wrong_key_read got %h want 01", data_out); else passed++;
  endtask

  task automatic test_lda;
    row_t rows[$];
    exp_t e;
    wr(16'h0000, 8'h02); wr(16'h0001, 8'h05);
    rows.push_back(mk(1'b1, 8'hB1, 1'b1, 8'h02, 1'b0));
    for (int i = 0; i < 3; i++) rows.push_back(mk(1'b0, 8'h00, 1'b1, 8'h02, 1'b0));
    rows.push_back(mk(1'b0, 8'h00, 1'b1, 8'h05, 1'b1));
    rows.push_back(mk(1'b1, 8'hEA, 1'b1, 8'h02, 1'b0));
    rows.push_back(mk(1'b0, 8'h00, 1'b1, 8'h02, 1'b0));
    foreach (rows[i]) begin
      cyc(rows[i].sync, 1'b1, 16'h2000, rows[i].op, rows[i].rdy);
      sb.push_back('{bank: rows[i].bank, sel: rows[i].sel, full: 1'b0});
      @(negedge clock);
      e = sb.pop_front();
      total++;
      if (bank !== e.bank || sel_indirect !== e.sel)
        $display("FAIL lda cycle %0d bank %h sel %b want bank %h sel %b", i, bank, sel_indirect, e.bank, e.sel);
      else passed++;
    end
  endtask

  task automatic test_sta;
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1'b1, 8'h91, 1'b1, 8'h02, 1'b0));
    for (int i = 0; i < 3; i++) rows.push_back(mk(1'b0, 8'h00, 1'b1, 8'h02, 1'b0));
    rows.push_back(mk(1'b0, 8'h00, 1'b1, 8'h05, 1'b1));
    rows.push_back(mk(1'b0, 8'h00, 1'b1, 8'h05, 1'b1));
    rows.push_back(mk(1'b1, 8'hEA, 1'b1, 8'h02, 1'b0));
    foreach (rows[i]) begin
      cyc(rows[i].sync, 1'b1, 16'h2000, rows[i].op, rows[i].rdy);
      sb.push_back('{bank: rows[i].bank, sel: rows[i].sel, full: 1'b0});
      @(negedge clock);
      e = sb.pop_front();
      total++;
      if (bank !== e.bank || sel_indirect !== e.sel)
        $display("FAIL sta cycle %0d bank %h sel %b want bank %h sel %b", i, bank, sel_indirect, e.bank, e.sel);
      else passed++;
    end
  endtask

  task automatic test_stall;
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1'b1, 8'hB1, 1'b1, 8'h02, 1'b0));
    for (int i = 0; i < 3; i++) rows.push_back(mk(1'b0, 8'h00, 1'b1, 8'h02, 1'b0));
    for (int i = 0; i < 3; i++) rows.push_back(mk(1'b0, 8'h00, 1'b0, 8'h05, 1'b1));
    rows.push_back(mk(1'b0, 8'h00, 1'b1, 8'h05, 1'b1));
    rows.push_back(mk(1'b0, 8'h00, 1'b1, 8'h05, 1'b1));
    rows.push_back(mk(1'b1, 8'hEA, 1'b1, 8'h02, 1'b0));
    foreach (rows[i]) begin
      cyc(rows[i].sync, 1'b1, 16'h2000, rows[i].op, rows[i].rdy);
      sb.push_back('{bank: rows[i].bank, sel: rows[i].sel, full: 1'b0});
      @(negedge clock);
      e = sb.pop_front();
      total++;
      if (bank !== e.bank || sel_indirect !== e.sel)
        $display("FAIL stall cycle %0d bank %h sel %b want bank %h sel %b", i, bank, sel_indirect, e.bank, e.sel);
      else passed++;
    end
  endtask

  task automatic test_non_match;
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1'b1, 8'hA1, 1'b1, 8'h02, 1'b0));
    rows.push_back(mk(1'b0, 8'h91, 1'b1, 8'h02, 1'b0));
    for (int i = 0; i < 5; i++) rows.push_back(mk(1'b0, 8'h00, 1'b1, 8'h02, 1'b0));
    foreach (rows[i]) begin
      cyc(rows[i].sync, 1'b1, 16'h2000, rows[i].op, rows[i].rdy);
      sb.push_back('{bank: rows[i].bank, sel: rows[i].sel, full: 1'b0});
      @(negedge clock);
      e = sb.pop_front();
      total++;
      if (bank !== e.bank || sel_indirect !== e.sel)
        $display("FAIL non_match cycle %0d bank %h sel %b want bank %h sel %b", i, bank, sel_indirect, e.bank, e.sel);
      else passed++;
    end
  endtask

  task automatic test_back_to_back;
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1'b1, 8'h91, 1'b1, 8'h02, 1'b0));
    for (int i = 0; i < 3; i++) rows.push_back(mk(1'b0, 8'h00, 1'b1, 8'h02, 1'b0));
    rows.push_back(mk(1'b0, 8'h00, 1'b1, 8'h05, 1'b1));
    rows.push_back(mk(1'b0, 8'h00, 1'b1, 8'h05, 1'b1));
    rows.push_back(mk(1'b1, 8'hB1, 1'b1, 8'h02, 1'b0));
    for (int i = 0; i < 3; i++) rows.push_back(mk(1'b0, 8'h00, 1'b1, 8'h02, 1'b0));
    rows.push_back(mk(1'b0, 8'h00, 1'b1, 8'h05, 1'b1));
    rows.push_back(mk(1'b1, 8'hEA, 1'b1, 8'h02, 1'b0));
    foreach (rows[i]) begin
      cyc(rows[i].sync, 1'b1, 16'h2000, rows[i].op, rows[i].rdy);
      sb.push_back('{bank: rows[i].bank, sel: rows[i].sel, full: 1'b0});
      @(negedge clock);
      e = sb.pop_front();
      total++;
      if (bank !== e.bank || sel_indirect !== e.sel)
        $display("FAIL back_to_back cycle %0d bank %h sel %b want bank %h sel %b", i, bank, sel_indirect, e.bank, e.sel);
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    row_t rows[$];
    exp_t e;
    cyc(1'b1, 1'b1, 16'h2000, 8'hB1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 16'h2000, 8'h00, 1'b1);
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    sb.push_back('{bank: 8'h0F, sel: 1'b0, full: 1'b0});
    e = sb.pop_front();
    total++; if (bank !== e.bank) $display("FAIL mid_reset_bank got %h want %h", bank, e.bank); else passed++;
    total++; if (sel_indirect !== e.sel) $display("FAIL mid_reset_sel got %b want %b", sel_indirect, e.sel); else passed++;
    #1 reset = 1'b0;
    wr(16'h0000, 8'h02); wr(16'h0001, 8'h05);
    rows.push_back(mk(1'b1, 8'h91, 1'b1, 8'h02, 1'b0));
    for (int i = 0; i < 3; i++) rows.push_back(mk(1'b0, 8'h00, 1'b1, 8'h02, 1'b0));
    rows.push_back(mk(1'b0, 8'h00, 1'b1, 8'h05, 1'b1));
    rows.push_back(mk(1'b0, 8'h00, 1'b1, 8'h05, 1'b1));
    rows.push_back(mk(1'b1, 8'hEA, 1'b1, 8'h02, 1'b0));
    foreach (rows[i]) begin
      cyc(rows[i].sync, 1'b1, 16'h2000, rows[i].op, rows[i].rdy);
      sb.push_back('{bank: rows[i].bank, sel: rows[i].sel, full: 1'b0});
      @(negedge clock);
      e = sb.pop_front();
      total++;
      if (bank !== e.bank || sel_indirect !== e.sel || full !== e.full)
        $display("FAIL after_reset cycle %0d bank %h sel %b full %b want bank %h sel %b full %b",
                 i, bank, sel_indirect, full, e.bank, e.sel, e.full);
      else passed++;
    end
  endtask

  initial begin
    test_reset;
    test_unlock;
    test_relock_wrong_key;
    test_lda;
    test_sta;
    test_stall;
    test_non_match;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bank_window_mapper.md
Name: bank_window_mapper

Overview:
- Parametrised successor to the 6502-in-6509-socket bank logic.
- Provides two memory-mapped bank registers at the bottom of the CPU address space: execution bank and indirect bank.
- An explicit cycle-tracking FSM switches the bank output to the indirect bank during the data cycles of matching (zp),Y opcodes.
- A key-sequence unlock FSM widens the bank output from LOCK_WIDTH bits to BANK_WIDTH bits.
- Sits between the CPU address/data bus and the system's upper address lines.

Parameters:
ADDR_WIDTH, 16, CPU address bus width
BANK_WIDTH, 8, bank output width when unlocked (1..8)
LOCK_WIDTH, 4, bank bits passed while locked (1..BANK_WIDTH); upper bits forced 0
RESET_BANK, 8'h0F, reset value of both bank registers (truncated to BANK_WIDTH)
OPC_MASK, 8'hDF, opcode compare mask
OPC_MATCH, 8'h91, masked opcode value (default matches $91 STA (zp),Y and $B1 LDA (zp),Y)
KEY0, 8'h55, first unlock byte
KEY1, 8'hAA, second unlock byte
KEY2, 8'h00, third unlock byte

Ports:
clock  input  1  CPU phi2; all state advances on rising edge
reset  input  1  asynchronous, active-high reset
rdy  input  1  CPU ready; low freezes the indirect FSM
sync  input  1  high during an opcode fetch cycle
r_w  input  1  1 = read, 0 = write
address  input  ADDR_WIDTH  CPU address
data_in  input  8  CPU data bus (write data / fetched opcode)
data_out  output  8  readback of bank register
data_oe  output  1  high when data_out must drive the CPU bus
bank  output  BANK_WIDTH  current bank address
full  output  1  unlock status
sel_indirect  output  1  high while bank selects the indirect register

Behaviour:
- Reset: exec_bank = indir_bank = RESET_BANK; full = 0; indirect FSM = IDLE; unlock FSM = K0. Resulting bank = RESET_BANK masked to LOCK_WIDTH; sel_indirect = 0.
- Reset asserted mid-sequence aborts both FSMs immediately (asynchronous).
- Register decode: hit = (address[ADDR_WIDTH-1:1] == 0). Address 0 selects exec_bank; address 1 selects indir_bank.
- Register write: hit & !r_w, captured on the rising clock edge, low BANK_WIDTH bits of data_in. Writes are NOT gated by rdy.
- Readback: data_oe = hit & r_w, combinational. data_out = selected register, zero-extended. When locked, bits at or above LOCK_WIDTH read 0.
- bank output: eff = sel_indirect ? indir_bank : exec_bank. bank = full ? eff : eff masked to LOCK_WIDTH.
- Indirect FSM states: IDLE, ZP, PLO, PHI, D1, D2. It advances only on edges where rdy = 1.
  - IDLE -> ZP when sync & ((data_in & OPC_MASK) == OPC_MATCH).
  - ZP -> PLO -> PHI -> D1: unconditional, one cycle each.
  - D1 -> D2 unconditional.
  - D2 -> IDLE; or D2 -> ZP if sync and the opcode matches (back-to-back instructions).
  - Any other state: if sync is seen while in ZP, PLO or PHI (interrupt or aborted decode), return to IDLE, or go to ZP on a match.
- sel_indirect, combinational: 1 in D1; 1 in D2 only while sync = 0. This covers the extra page-cross/dummy cycle: LDA without page crossing exits at the sync of the next opcode, and that fetch uses exec_bank.
- With rdy = 0: state holds and sel_indirect holds its value for the stretched cycle.
- Unlock FSM (advances only on writes to address 1, when the bank output is not already selecting the indirect register):
  - K0: data == KEY0 -> K1, else stay K0.
  - K1: data == KEY1 -> K2, else K0.
  - K2: data == KEY2 -> K3, else K0.
  - K3: full <= data_in[0], -> K0.
  - Writes to address 0 or to other addresses do not affect the FSM.
  - Key writes also update indir_bank normally.
- Simultaneous events: a register write in the same cycle as an FSM transition takes effect for bank from the next cycle. The FSM transition uses the pre-write register values.

Test Plan:
- Reset then idle reads: read $0000 and $0001 -> data_oe = 1, data_out = $0F; bank = $0F; full = 0.
- Write $3A to $0000 while locked -> bank = $0A, readback $0A. Then unlock with writes $55, $AA, $00, $01 to $0001 -> full = 1, bank = $3A, readback $0000 = $3A.
- Wrong key: writes $55, $AB, $00, $01 to $0001 -> full stays 0. Then re-lock from unlocked: $55, $AA, $00, $00 -> full = 0.
- exec = $02, indir = $05, opcode $B1 at sync, no page cross -> bank = $02 for 4 cycles, $05 for 1 cycle (D1), then $02 at the next sync. STA $91 -> $05 for 2 cycles (D1, D2).
- Same LDA with rdy low for 3 cycles during D1 -> bank holds $05 through the stall, then D2 proceeds. Opcode $A1 -> no indirect selection.
- Assert reset in PHI -> bank = $0F immediately, FSM IDLE. A following $91 sequence behaves as in the STA scenario.
